// File: rtl/never8_pkg.sv
// Shared definitions for the Never8 fetch/execute sequencer: widths, opcodes,
// FSM state encoding and jump-condition selectors.
package never8_pkg;

    localparam int DATA_W = 8;
    localparam int PC_W   = 5;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_LDI = 3'd2;
    localparam logic [2:0] OP_JZ  = 3'd3;
    localparam logic [2:0] OP_JC  = 3'd4;
    localparam logic [2:0] OP_JMP = 3'd5;
    localparam logic [2:0] OP_OUT = 3'd6;
    localparam logic [2:0] OP_HLT = 3'd7;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_OUTW  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // All-zero selector means an unconditional jump.
    localparam logic [1:0] JC_ALWAYS = 2'b00;
    localparam logic [1:0] JC_Z      = 2'b01;
    localparam logic [1:0] JC_C      = 2'b10;

endpackage

// File: rtl/never8_decode.sv
// Combinational opcode decoder: turns ir[7:5] into the one-hot control
// strobes consumed by the execute stage.
module never8_decode
    import never8_pkg::*;
(
    input  logic [2:0] opcode,
    output logic       wr_acc,
    output logic       wr_flags,
    output logic       is_ldi,
    output logic       is_jump,
    output logic [1:0] jump_cond_sel,
    output logic       is_out,
    output logic       is_hlt
);

    always_comb begin
        wr_acc        = 1'b0;
        wr_flags      = 1'b0;
        is_ldi        = 1'b0;
        is_jump       = 1'b0;
        jump_cond_sel = JC_ALWAYS;
        is_out        = 1'b0;
        is_hlt        = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB: begin
                wr_acc   = 1'b1;
                wr_flags = 1'b1;
            end
            OP_LDI: begin
                wr_acc = 1'b1;
                is_ldi = 1'b1;
            end
            OP_JZ: begin
                is_jump       = 1'b1;
                jump_cond_sel = JC_Z;
            end
            OP_JC: begin
                is_jump       = 1'b1;
                jump_cond_sel = JC_C;
            end
            OP_JMP: is_jump = 1'b1;
            OP_OUT: is_out  = 1'b1;
            OP_HLT: is_hlt  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/never8_control.sv
// Never8 fetch/execute sequencer: owns pc, ir, acc and Z/C, drives the ALU.
// NEVER8_OUT_HANDSHAKE_EN: OUT waits in OUTW for out_ready instead of pulsing.
module never8_control
    import never8_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   imem_addr,
    output logic              imem_req,
    input  logic              imem_valid,
    input  logic [DATA_W-1:0] imem_data,
    output logic [2:0]        alu_opcode,
    output logic [PC_W-1:0]   alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              alu_c,
    input  logic              alu_zflag,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] acc,
    output logic              halted
);

    state_t            state_reg;
    logic [PC_W-1:0]   pc_reg;
    logic [DATA_W-1:0] ir_reg;
    logic [DATA_W-1:0] acc_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic              z_reg;
    logic              c_reg;
    logic              out_valid_reg;
    logic              halted_reg;

    logic              wr_acc, wr_flags, is_ldi, is_jump, is_out, is_hlt;
    logic [1:0]        jump_cond_sel;
    logic              jump_taken;
    logic [PC_W-1:0]   pc_next;
    logic [DATA_W-1:0] acc_next;

    never8_decode u_decode (
        .opcode        (ir_reg[7:5]),
        .wr_acc        (wr_acc),
        .wr_flags      (wr_flags),
        .is_ldi        (is_ldi),
        .is_jump       (is_jump),
        .jump_cond_sel (jump_cond_sel),
        .is_out        (is_out),
        .is_hlt        (is_hlt)
    );

    assign jump_taken = is_jump &&
                        ((jump_cond_sel == JC_ALWAYS) ||
                         (jump_cond_sel[0] && z_reg) ||
                         (jump_cond_sel[1] && c_reg));
    // PC_W-bit add wraps 31 back to 0 for free.
    assign pc_next  = jump_taken ? ir_reg[PC_W-1:0] : pc_reg + 1'b1;
    assign acc_next = is_ldi ? {{(DATA_W-PC_W){1'b0}}, ir_reg[PC_W-1:0]} : alu_data;

    assign imem_addr  = pc_reg;
    assign imem_req   = (state_reg == ST_FETCH) && !rst;
    assign alu_opcode = ir_reg[7:5];
    assign alu_a      = ir_reg[PC_W-1:0];
    assign alu_b      = acc_reg;
    assign out_data   = out_data_reg;
    assign out_valid  = out_valid_reg;
    assign acc        = acc_reg;
    assign halted     = halted_reg;

`ifndef NEVER8_OUT_HANDSHAKE_EN
    logic unused_out_ready;
    assign unused_out_ready = out_ready;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_FETCH;
            pc_reg        <= '0;
            ir_reg        <= '0;
            acc_reg       <= '0;
            z_reg         <= 1'b0;
            c_reg         <= 1'b0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            halted_reg    <= 1'b0;
        end else begin
`ifndef NEVER8_OUT_HANDSHAKE_EN
            out_valid_reg <= 1'b0;
`endif
            case (state_reg)
                ST_FETCH: begin
                    if (imem_valid) begin
                        ir_reg    <= imem_data;
                        state_reg <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    pc_reg    <= pc_next;
                    state_reg <= ST_FETCH;
                    if (wr_acc) acc_reg <= acc_next;
                    if (wr_flags) begin
                        z_reg <= alu_zflag;
                        c_reg <= alu_c;
                    end
                    if (is_out) begin
                        out_data_reg  <= acc_reg;
                        out_valid_reg <= 1'b1;
`ifdef NEVER8_OUT_HANDSHAKE_EN
                        state_reg     <= ST_OUTW;
`endif
                    end
                    if (is_hlt) begin
                        halted_reg <= 1'b1;
                        state_reg  <= ST_HALT;
                    end
                end
`ifdef NEVER8_OUT_HANDSHAKE_EN
                ST_OUTW: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_FETCH;
                    end
                end
`endif
                ST_HALT: ;
                default: state_reg <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_never8_control.sv
// Scoreboard bench for never8_control: directed programs, a behavioural ALU and
// instruction memory with programmable wait states.
module tb_never8_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] imem_addr;
    logic       imem_req;
    logic       imem_valid = 1'b0;
    logic [7:0] imem_data = 8'h00;
    logic [2:0] alu_opcode;
    logic [4:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_data;
    logic       alu_c;
    logic       alu_zflag;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] acc;
    logic       halted;

    never8_control dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_data   (alu_data),
        .alu_c      (alu_c),
        .alu_zflag  (alu_zflag),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .acc        (acc),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: ADD zero-extends imm, SUB is acc + ~imm + 1.
    logic [8:0] alu_sum;
    always_comb begin
        alu_sum = 9'd0;
        if (alu_opcode[0])
            alu_sum = {1'b0, alu_b} + {1'b0, ~{3'b000, alu_a}} + 9'd1;
        else
            alu_sum = {1'b0, alu_b} + {4'b0000, alu_a};
    end
    assign alu_data  = alu_sum[7:0];
    assign alu_c     = alu_sum[8];
    assign alu_zflag = (alu_sum[7:0] == 8'h00);

    typedef struct {
        logic [7:0] acc;
        logic [4:0] pc;
        logic       z;
        logic       c;
        logic       halted;
        logic       ov;
        logic [7:0] od;
        int         req;
    } exp_t;

    exp_t       exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] mem [32];
    int         fetch_wait = 0;
    logic       inject     = 1'b0;

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic expect_tx(input logic [7:0] a, input logic [4:0] p, input logic z, input logic c,
                             input logic h, input logic ov, input logic [7:0] od, input int req);
        exp_t e;
        e.acc = a; e.pc = p; e.z = z; e.c = c; e.halted = h; e.ov = ov; e.od = od; e.req = req;
        exp_q.push_back(e);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = 8'hE0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic sample();
        @(negedge clk); #3;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            sample();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout: %0d transactions outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Instruction memory: answers fetches after fetch_wait idle cycles.
    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(negedge clk);
            if (inject) begin
                imem_valid = 1'b1;
                imem_data  = 8'h5F;
            end else if (rst || !imem_req) begin
                imem_valid = 1'b0;
                if (rst) wcnt = fetch_wait;
            end else if (wcnt > 0) begin
                imem_valid = 1'b0;
                wcnt--;
            end else begin
                imem_valid = 1'b1;
                imem_data  = mem[imem_addr];
                wcnt       = fetch_wait;
            end
        end
    end

    // Monitor: fetch accepted -> EXEC cycle -> results visible one cycle later.
    initial begin
        int   phase;
        int   cnt;
        int   fetch_req;
        exp_t e;
        phase = 0; cnt = 0; fetch_req = 0;
        forever begin
            @(negedge clk); #2;
            if (rst) begin
                phase = 0;
                cnt   = 0;
            end else if (phase == 1) begin
                phase = 2;
            end else begin
                if (phase == 2) begin
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        $display("TX pc=%0d acc=0x%02h z=%0b c=%0b halted=%0b out_valid=%0b out_data=0x%02h req=%0d",
                                 imem_addr, acc, dut.z_reg, dut.c_reg, halted, out_valid, out_data, fetch_req);
                        chk("tx_acc", acc, e.acc);
                        chk("tx_pc", imem_addr, e.pc);
                        chk("tx_z", dut.z_reg, e.z);
                        chk("tx_c", dut.c_reg, e.c);
                        chk("tx_halted", halted, e.halted);
                        chk("tx_out_valid", out_valid, e.ov);
                        chk("tx_out_data", out_data, e.od);
                        chk("tx_req_cycles", fetch_req, e.req);
                    end
                    phase = 0;
                end
                if (imem_req) begin
                    cnt++;
                    if (imem_valid) begin
                        fetch_req = cnt;
                        cnt       = 0;
                        phase     = 1;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nov;
        logic data_ok;

        // Reset plus arithmetic: LDI 5, ADD 3, SUB 8, JC 9 (taken), HLT.
        clear_mem();
        mem[0] = 8'h45; mem[1] = 8'h03; mem[2] = 8'h28; mem[3] = 8'h89; mem[9] = 8'hE0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk); #3;
        chk("rst_imem_req", imem_req, 1'b0);
        chk("rst_pc", imem_addr, 5'd0);
        chk("rst_acc", acc, 8'h00);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_halted", halted, 1'b0);
        expect_tx(8'h05, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1);
        expect_tx(8'h08, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1);
        expect_tx(8'h00, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1);
        expect_tx(8'h00, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1);
        expect_tx(8'h00, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1);
        @(posedge clk); #1 rst = 1'b0;
        sample();
        chk("post_rst_imem_req", imem_req, 1'b1);
        wait_drain(40, "arith");
        for (int k = 0; k < 5; k++) begin
            sample();
            chk("halt_imem_req", imem_req, 1'b0);
            chk("halt_halted", halted, 1'b1);
        end

        // JZ taken: ADD 0 sets Z, JZ 10, HLT at 10.
        clear_mem();
        mem[0] = 8'h00; mem[1] = 8'h6A; mem[10] = 8'hE0;
        expect_tx(8'h00, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1);
        expect_tx(8'h00, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1);
        expect_tx(8'h00, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1);
        do_reset();
        wait_drain(40, "jz");

        // Not-taken branches: LDI 3, SUB 5 (0xFE, C=0), JC 7, JZ 31, HLT.
        clear_mem();
        mem[0] = 8'h43; mem[1] = 8'h25; mem[2] = 8'h87; mem[3] = 8'h7F; mem[4] = 8'hE0;
        expect_tx(8'h03, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1);
        expect_tx(8'hFE, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1);
        expect_tx(8'hFE, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1);
        expect_tx(8'hFE, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1);
        expect_tx(8'hFE, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1);
        do_reset();
        wait_drain(40, "not_taken");

        // PC wrap with 3 wait states per fetch: JMP 31, LDI 3 at 31 -> pc 0.
        clear_mem();
        fetch_wait = 3;
        mem[0] = 8'hBF; mem[31] = 8'h43;
        expect_tx(8'h00, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4);
        expect_tx(8'h03, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4);
        do_reset();
        wait_drain(80, "wrap");
        fetch_wait = 0;

        // OUT of 0x2A with out_ready low for 3 cycles then high.
        clear_mem();
        mem[0] = 8'h55; mem[1] = 8'h15; mem[2] = 8'hC0; mem[3] = 8'hE0;
        expect_tx(8'h15, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1);
        expect_tx(8'h2A, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1);
        expect_tx(8'h2A, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h2A, 1);
        expect_tx(8'h2A, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 8'h2A, 1);
        out_ready = 1'b0;
        do_reset();
        n = 0;
        while (!out_valid && n < 40) begin
            sample();
            n++;
        end
        chk("out_valid_seen", out_valid, 1'b1);
        nov = out_valid ? 1 : 0;
        data_ok = (out_data == 8'h2A);
        for (int k = 1; k < 8; k++) begin
            @(posedge clk); #1;
            if (k == 3) out_ready = 1'b1;
            @(negedge clk); #3;
            if (out_valid) begin
                nov++;
                if (out_data != 8'h2A) data_ok = 1'b0;
            end
        end
        out_ready = 1'b0;
`ifdef NEVER8_OUT_HANDSHAKE_EN
        chk("out_valid_cycles", nov, 4);
`else
        chk("out_valid_cycles", nov, 1);
`endif
        chk("out_data_stable", data_ok, 1'b1);
        wait_drain(40, "out");

        // Reset during a FETCH wait state with imem_valid raised on the same edge.
        clear_mem();
        fetch_wait = 5;
        mem[0] = 8'h44;
        expect_tx(8'h04, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 6);
        do_reset();
        wait_drain(60, "pre_abort");
        @(posedge clk); #1;
        rst = 1'b1;
        inject = 1'b1;
        sample();
        chk("abort_pre_pc", imem_addr, 5'd1);
        chk("abort_pre_valid", imem_valid, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        inject = 1'b0;
        sample();
        chk("abort_pc", imem_addr, 5'd0);
        chk("abort_acc", acc, 8'h00);
        chk("abort_ir_opcode", alu_opcode, 3'd0);
        chk("abort_ir_imm", alu_a, 5'd0);
        fetch_wait = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
